// File: rtl/switch_arb_pkg.sv
// Shared types, default widths and the round-robin pointer helper for the
// switch ingress arbiter.
package switch_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF = 16;

  // Wraps explicitly so that non-power-of-two requester counts roll over to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
    return (ptr + 32'd1 >= num_req) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/switch_ingress_arb_rr_picker.sv
// Combinational round-robin search: first set request at or after start_i,
// wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    int unsigned j;
    logic [IDX_W-1:0] jj;
    logic hit;
    hit   = 1'b0;
    idx_o = '0;
    j     = 0;
    jj    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j  = (32'(start_i) + k) % NUM_REQ;
      jj = IDX_W'(j);
      if (!hit && req_i[jj]) begin
        hit   = 1'b1;
        idx_o = jj;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/switch_ingress_arb.sv
// Round-robin arbiter sharing the switch ingress port between NUM_REQ
// valid/ready requesters, with bounded bursts and a registered output beat.
module switch_ingress_arb
  import switch_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic [DATA_WIDTH-1:0]         data,
  output logic                          vld,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
  output logic                          busy
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  arb_state_t              state_q, state_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [IW-1:0]           rr_q, rr_d;
  logic [CW-1:0]           beat_q, beat_d;
  logic                    bubble_q, bubble_d;
  logic                    vld_q, vld_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic [IW-1:0]           owner_nxt;
  logic [IW-1:0]           pick_start;
  logic [IW-1:0]           pick_idx;
  logic                    pick_found;
  logic                    xfer;
  logic                    burst_end;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;

  assign owner_nxt  = IW'(rr_next(32'(owner_q), NUM_REQ));
  assign pick_start = (state_q == GRANT) ? owner_nxt : rr_q;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_picker (
    .req_i   (req_vld),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // bubble_q blanks ready for the cycle after a re-pick so ready never
  // depends on the same-cycle pick result.
  always_comb begin
    req_rdy = '0;
    if (state_q == GRANT && en && !bubble_q) req_rdy[owner_q] = 1'b1;
  end

  assign xfer = |(req_rdy & req_vld);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    beat_d    = beat_q;
    bubble_d  = bubble_q;
    vld_d     = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    burst_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && pick_found) begin
          state_d = GRANT;
          owner_d = pick_idx;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (en && bubble_q) begin
          bubble_d = 1'b0;
        end else if (en) begin
          if (xfer) begin
            vld_d     = 1'b1;
            addr_d    = sel_addr;
            data_d    = sel_data;
            beat_d    = beat_q + CW'(1);
            burst_end = (beat_q == CW'(BURST_MAX - 1));
          end else begin
            burst_end = 1'b1;
          end
          if (burst_end) begin
            rr_d   = owner_nxt;
            beat_d = '0;
            if (pick_found) begin
              owner_d  = pick_idx;
              bubble_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      beat_q   <= '0;
      bubble_q <= 1'b0;
      vld_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      beat_q   <= beat_d;
      bubble_q <= bubble_d;
      vld_q    <= vld_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign vld    = vld_q;
  assign addr   = addr_q;
  assign data   = data_q;
  assign gnt_id = owner_q;
  assign busy   = (state_q == GRANT);

endmodule

// File: tb/tb_switch_ingress_arb.sv
// Bench for switch_ingress_arb: behavioural arbitration model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_switch_ingress_arb;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int BM = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            en;
  logic [N-1:0]    vld_in;
  logic [AW-1:0]   a_in [N];
  logic [DW-1:0]   d_in [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_rdy;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   data;
  logic            vld;
  logic [1:0]      gnt_id;
  logic            busy;

  logic            en3;
  logic [2:0]      rv3;
  logic [3*AW-1:0] ra3;
  logic [3*DW-1:0] rd3;
  logic [2:0]      rdy3;
  logic [AW-1:0]   addr3;
  logic [DW-1:0]   data3;
  logic            vld3;
  logic [1:0]      gnt3;
  logic            busy3;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a_in[i];
      req_data[i*DW +: DW] = d_in[i];
    end
  end

  switch_ingress_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM)) u_dut (
    .clk(clk), .rstn(rstn), .en(en), .req_vld(vld_in), .req_addr(req_addr),
    .req_data(req_data), .req_rdy(req_rdy), .addr(addr), .data(data), .vld(vld),
    .gnt_id(gnt_id), .busy(busy)
  );

  switch_ingress_arb #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM)) u_dut3 (
    .clk(clk), .rstn(rstn), .en(en3), .req_vld(rv3), .req_addr(ra3),
    .req_data(rd3), .req_rdy(rdy3), .addr(addr3), .data(data3), .vld(vld3),
    .gnt_id(gnt3), .busy(busy3)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int          obs_cyc [$];
  logic [15:0] obs_data[$];
  logic [15:0] obs3    [$];

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: owner, beats so far, hold-off cycle, pointer, output beat.
  bit          m_busy = 0, m_hold = 0, m_vld = 0, m_end = 0;
  int          m_owner = 0, m_beats = 0, m_rr = 0;
  logic [7:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic [3:0]  exp_rdy;

  function automatic int pick(input logic [3:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_busy = 0; m_hold = 0; m_vld = 0; m_owner = 0; m_beats = 0; m_rr = 0;
      m_addr = '0; m_data = '0;
    end else begin
      m_vld = 0;
      if (!m_busy) begin
        if (en && vld_in != 0) begin
          m_owner = pick(vld_in, m_rr); m_beats = 0; m_busy = 1; m_hold = 0;
        end
      end else if (en) begin
        if (m_hold) m_hold = 0;
        else begin
          m_end = 0;
          if (vld_in[m_owner]) begin
            m_vld = 1; m_addr = a_in[m_owner]; m_data = d_in[m_owner];
            m_beats++;
            m_end = (m_beats == BM);
          end else m_end = 1;
          if (m_end) begin
            m_rr = (m_owner + 1) % N;
            m_beats = 0;
            if (vld_in != 0) begin m_owner = pick(vld_in, m_rr); m_hold = 1; end
            else m_busy = 0;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    exp_rdy = (m_busy && en && !m_hold) ? 4'(1 << m_owner) : 4'b0;
    chk("rdy",    req_rdy, exp_rdy);
    chk("vld",    vld,     m_vld);
    chk("addr",   addr,    m_addr);
    chk("data",   data,    m_data);
    chk("gnt_id", gnt_id,  m_owner);
    chk("busy",   busy,    m_busy);
    if (vld) begin obs_data.push_back(data); obs_cyc.push_back(cyc); end
    if (vld3) obs3.push_back(data3);
    cyc++;
  end

  // Directed driver: each requester offers left[i] beats, data = base + index.
  int unsigned left[N];
  int unsigned sent[N];
  logic [15:0] base[N];

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      vld_in[i] = (left[i] != 0);
      d_in[i]   = base[i] + 16'(sent[i]);
    end
  endtask

  task automatic run_cycle();
    logic [N-1:0] x;
    @(negedge clk); #1;
    x = req_rdy & vld_in;
    @(posedge clk); #2;
    for (int i = 0; i < N; i++) if (x[i]) begin sent[i]++; left[i]--; end
    apply();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rstn = 1'b0; en = 1'b0; vld_in = '0; en3 = 1'b0; rv3 = '0;
    for (int i = 0; i < N; i++) begin left[i] = 0; sent[i] = 0; base[i] = '0; end
    @(negedge clk);
    chk("rst_vld", vld, 0);  chk("rst_busy", busy, 0); chk("rst_gnt", gnt_id, 0);
    chk("rst_rdy", req_rdy, 0); chk("rst_addr", addr, 0); chk("rst_data", data, 0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    obs_data.delete(); obs_cyc.delete(); obs3.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, mn, mx, dens;
    int cnt[N];
    rstn = 1'b0; en = 1'b0; vld_in = '0; en3 = 1'b0; rv3 = '0; ra3 = '0; rd3 = '0;
    for (int i = 0; i < N; i++) begin a_in[i] = 8'(8'h05 + i); d_in[i] = '0; end

    // Single requester, 6 beats, bubble after beat 4.
    do_reset();
    a_in[1] = 8'h05; base[1] = 16'h1000; left[1] = 6; en = 1'b1; apply();
    repeat (20) run_cycle();
    chk("A_beats", obs_data.size(), 6);
    if (obs_data.size() == 6) begin
      for (int b = 0; b < 6; b++) chk("A_data", obs_data[b], 16'h1000 + 16'(b));
      for (int b = 1; b < 6; b++) chk("A_gap", obs_cyc[b] - obs_cyc[b-1], (b == 4) ? 2 : 1);
    end
    chk("A_addr", addr, 8'h05);
    chk("A_gnt", gnt_id, 1);

    // All four requesters always valid.
    do_reset();
    for (int i = 0; i < N; i++) begin base[i] = 16'(i << 12); left[i] = 1000; end
    en = 1'b1; apply();
    repeat (40) run_cycle();
    chk("B_enough", obs_data.size() >= 16, 1);
    if (obs_data.size() >= 16)
      for (int b = 0; b < 16; b++) chk("B_order", obs_data[b][15:12], (b / 4) % 4);
    for (int i = 0; i < N; i++) cnt[i] = 0;
    foreach (obs_data[b]) cnt[obs_data[b][13:12]]++;
    mn = cnt[0]; mx = cnt[0];
    for (int i = 1; i < N; i++) begin
      if (cnt[i] < mn) mn = cnt[i];
      if (cnt[i] > mx) mx = cnt[i];
    end
    chk("B_fair", (mx - mn) <= 4, 1);
    for (int i = 0; i < N; i++) left[i] = 0;
    apply();
    repeat (6) run_cycle();

    // Early release: req2 stops after 2 beats while req3 waits.
    do_reset();
    base[2] = 16'h2000; left[2] = 2; base[3] = 16'h3000; left[3] = 2;
    en = 1'b1; apply();
    repeat (15) run_cycle();
    chk("C_beats", obs_data.size(), 4);
    if (obs_data.size() == 4) begin
      chk("C_d0", obs_data[0], 16'h2000); chk("C_d1", obs_data[1], 16'h2001);
      chk("C_d2", obs_data[2], 16'h3000); chk("C_d3", obs_data[3], 16'h3001);
      chk("C_gap", obs_cyc[2] - obs_cyc[1], 3);
    end

    // en low for 5 cycles after the second beat.
    do_reset();
    base[0] = 16'h0000; left[0] = 6; en = 1'b1; apply();
    k = 0;
    while (sent[0] < 2 && k < 20) begin run_cycle(); k++; end
    chk("D_start", sent[0], 2);
    en = 1'b0;
    repeat (5) begin
      run_cycle();
      chk("D_rdy", req_rdy, 0); chk("D_vld", vld, 0);
      chk("D_busy", busy, 1);   chk("D_gnt", gnt_id, 0);
    end
    en = 1'b1;
    repeat (15) run_cycle();
    chk("D_beats", obs_data.size(), 6);
    if (obs_data.size() == 6) begin
      for (int b = 0; b < 6; b++) chk("D_data", obs_data[b], 16'(b));
      chk("D_gap1", obs_cyc[1] - obs_cyc[0], 1); chk("D_gap2", obs_cyc[2] - obs_cyc[1], 6);
      chk("D_gap3", obs_cyc[3] - obs_cyc[2], 1); chk("D_gap4", obs_cyc[4] - obs_cyc[3], 2);
      chk("D_gap5", obs_cyc[5] - obs_cyc[4], 1);
    end

    // Asynchronous reset during req1's burst.
    do_reset();
    base[0] = 16'h0000; left[0] = 100; base[1] = 16'h1000; left[1] = 100;
    en = 1'b1; apply();
    k = 0;
    while (sent[1] < 2 && k < 30) begin run_cycle(); k++; end
    chk("E_mid", sent[1], 2);
    chk("E_owner", gnt_id, 1);
    #1 rstn = 1'b0;
    #1;
    chk("E_vld", vld, 0); chk("E_busy", busy, 0);
    chk("E_rdy", req_rdy, 0); chk("E_gnt", gnt_id, 0);
    repeat (2) @(posedge clk);
    #2;
    obs_data.delete(); obs_cyc.delete();
    rstn = 1'b1;
    repeat (6) run_cycle();
    chk("E_any", obs_data.size() > 0, 1);
    if (obs_data.size() > 0) chk("E_first", obs_data[0][15:12], 0);
    for (int i = 0; i < N; i++) left[i] = 0;
    apply();

    // Three requesters, 0 and 2 active: alternate across the wrap.
    do_reset();
    rd3 = {16'h2222, 16'h1111, 16'h0000}; ra3 = '0;
    en3 = 1'b1; rv3 = 3'b101;
    repeat (45) @(posedge clk);
    chk("F_enough", obs3.size() >= 16, 1);
    if (obs3.size() >= 16)
      for (int b = 0; b < 16; b++) chk("F_order", obs3[b], ((b / 4) % 2) ? 16'h2222 : 16'h0000);
    en3 = 1'b0; rv3 = '0;

    // Random traffic against the model.
    do_reset();
    dens = 50;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if (c % 200 == 0) dens = $urandom_range(10, 100);
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) begin
        vld_in[i] = ($urandom_range(0, 99) < dens);
        a_in[i]   = 8'($urandom);
        d_in[i]   = 16'($urandom);
      end
    end
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
